// File: rtl/pipo_pkg.sv
// rtl/pipo_pkg.sv - shared sizing helpers for the multiplier-path PIPO buffers
// Contents:
//   is_pow2(n) : 1 when n is a power of two and at least 2 (legal DEPTH)
//   ptr_w(n)   : pointer width for an n-entry buffer
//   cnt_w(n)   : occupancy counter width for an n-entry buffer (holds 0..n)
package pipo_pkg;

  function automatic bit is_pow2(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int ptr_w(int n);
    return $clog2(n);
  endfunction

  // One extra bit so a full buffer (count == n) is distinguishable from empty.
  function automatic int cnt_w(int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pipo_ptr.sv
// rtl/pipo_ptr.sv - wrapping buffer pointer with synchronous clear and increment enable
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, pointer to 0
//   clear : synchronous clear, pointer to 0 (wins over inc)
//   inc   : advance pointer by one, wrapping modulo 2**ADDR_W
//   ptr   : current pointer value
module pipo_ptr #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // DEPTH is a power of two, so natural binary overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pipo_buffer.sv
// rtl/pipo_buffer.sv - first-word-fall-through PIPO buffer with done pulse, flush, count and overflow
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : synchronous clear of contents (overflow kept if re-triggered)
//   in_data/in_valid    : write word and request (legacy start)
//   in_ready            : space available; depends on registered count only
//   out_data/out_valid  : head word and its qualifier
//   out_ready           : consumer takes head word
//   count               : stored words, 0..DEPTH
//   done                : one-cycle pulse after each accepted write
//   overflow            : sticky, a write was attempted while full
module pipo_buffer
  import pipo_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              overflow
);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("pipo_buffer: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              full;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_go;
  logic              rd_go;
  logic              ovf_cond;

  // Handshake qualifiers come from registered count only, so there is no
  // in_valid->out_valid or out_ready->in_ready combinational path.
  assign full      = (count == FULL_CNT);
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign ovf_cond = in_valid && full;

  // Traffic in a flush cycle is discarded.
  assign wr_go = wr_fire && !flush;
  assign rd_go = rd_fire && !flush;

  pipo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (wr_go),
    .ptr   (wr_ptr)
  );

  pipo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (rd_go),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (wr_go && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      done <= 1'b0;
    end else begin
      done <= wr_fire;
    end
  end

  // A flush clears the sticky flag unless a write hits a full buffer in the
  // very same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= ovf_cond;
    end else begin
      overflow <= overflow || ovf_cond;
    end
  end

endmodule

// File: tb/tb_pipo_buffer.sv
// tb/tb_pipo_buffer.sv - table-driven self-checking bench for pipo_buffer
module tb_pipo_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        done;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipo_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .done      (done),
    .overflow  (overflow)
  );

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [2:0]  cnt;
    logic        rdy;
    logic        vld;
    logic        chk;
    logic [31:0] data;
    logic        dn;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [31:0] d,
                     input logic ordy, input logic [2:0] cnt, input logic rdy, input logic vld,
                     input logic chk, input logic [31:0] data, input logic dn, input logic ovf);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.cnt = cnt; v.rdy = rdy; v.vld = vld; v.chk = chk; v.data = data; v.dn = dn; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit after
  // the rising edge that consumed them.
  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      cmp("count",     i, {29'd0, count}, {29'd0, vecs[i].cnt});
      cmp("in_ready",  i, {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      cmp("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].vld});
      cmp("done",      i, {31'd0, done}, {31'd0, vecs[i].dn});
      cmp("overflow",  i, {31'd0, overflow}, {31'd0, vecs[i].ovf});
      if (vecs[i].chk) cmp("out_data", i, out_data, vecs[i].data);
    end
    vecs.delete();
  endtask

  initial begin
    // reset, then idle
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // single word, one-cycle latency, done pulse width
    add(0, 0, 1, 32'hDEADBEEF, 0, 1, 1, 1, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0, 0,            0, 1, 1, 1, 1, 32'hDEADBEEF, 0, 0);
    add(0, 0, 0, 0,            1, 0, 1, 0, 0, 0,            0, 0);
    // fill and overflow; a same-cycle read does not rescue a write at full
    add(0, 0, 1, 32'h1, 0, 1, 1, 1, 1, 32'h1, 1, 0);
    add(0, 0, 1, 32'h2, 0, 2, 1, 1, 1, 32'h1, 1, 0);
    add(0, 0, 1, 32'h3, 0, 3, 1, 1, 1, 32'h1, 1, 0);
    add(0, 0, 1, 32'h4, 0, 4, 0, 1, 1, 32'h1, 1, 0);
    add(0, 0, 1, 32'h5, 0, 4, 0, 1, 1, 32'h1, 0, 1);
    add(0, 0, 1, 32'h6, 1, 3, 1, 1, 1, 32'h2, 0, 1);
    add(0, 0, 0, 0,     1, 2, 1, 1, 1, 32'h3, 0, 1);
    add(0, 0, 0, 0,     1, 1, 1, 1, 1, 32'h4, 0, 1);
    add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0,     0, 1);
    add(0, 0, 0, 0,     1, 0, 1, 0, 0, 0,     0, 1);  // read while empty
    // flush at count 3 with colliding write and read; pointers non-zero
    add(0, 0, 1, 32'h11, 0, 1, 1, 1, 1, 32'h11, 1, 1);
    add(0, 0, 1, 32'h22, 0, 2, 1, 1, 1, 32'h11, 1, 1);
    add(0, 0, 1, 32'h33, 0, 3, 1, 1, 1, 32'h11, 1, 1);
    add(0, 0, 0, 0,      1, 2, 1, 1, 1, 32'h22, 0, 1);
    add(0, 0, 1, 32'h44, 0, 3, 1, 1, 1, 32'h22, 1, 1);
    add(0, 1, 1, 32'h55, 1, 0, 1, 0, 0, 0,      0, 0);
    add(0, 0, 0, 0,      0, 0, 1, 0, 0, 0,      0, 0);
    // first word after flush comes from entry 0; flush at full with write keeps overflow
    add(0, 0, 1, 32'h66, 0, 1, 1, 1, 1, 32'h66, 1, 0);
    add(0, 0, 1, 32'h77, 0, 2, 1, 1, 1, 32'h66, 1, 0);
    add(0, 0, 1, 32'h88, 0, 3, 1, 1, 1, 32'h66, 1, 0);
    add(0, 0, 1, 32'h99, 0, 4, 0, 1, 1, 32'h66, 1, 0);
    add(0, 1, 1, 32'hAA, 0, 0, 1, 0, 0, 0,      0, 1);
    add(0, 1, 0, 0,      0, 0, 1, 0, 0, 0,      0, 0);
    // reset mid-stream at count 2 with overflow set and a write pending
    add(0, 0, 1, 32'hB1, 0, 1, 1, 1, 1, 32'hB1, 1, 0);
    add(0, 0, 1, 32'hB2, 0, 2, 1, 1, 1, 32'hB1, 1, 0);
    add(0, 0, 1, 32'hB3, 0, 3, 1, 1, 1, 32'hB1, 1, 0);
    add(0, 0, 1, 32'hB4, 0, 4, 0, 1, 1, 32'hB1, 1, 0);
    add(0, 0, 1, 32'hB5, 0, 4, 0, 1, 1, 32'hB1, 0, 1);
    add(0, 0, 0, 0,      1, 3, 1, 1, 1, 32'hB2, 0, 1);
    add(0, 0, 0, 0,      1, 2, 1, 1, 1, 32'hB3, 0, 1);
    add(1, 0, 1, 32'hC0, 1, 0, 1, 0, 0, 0,      0, 0);
    add(0, 0, 1, 32'hA5, 0, 1, 1, 1, 1, 32'hA5, 1, 0);
    add(0, 0, 0, 0,      0, 1, 1, 1, 1, 32'hA5, 0, 0);
    run_vecs();

    // Concurrent traffic at count 2: output lags input by two words and the
    // pointers wrap five times over the 20 cycles.
    add(0, 0, 0, 0,       1, 0, 1, 0, 0, 0,       0, 0);
    add(0, 0, 1, 32'h100, 0, 1, 1, 1, 1, 32'h100, 1, 0);
    add(0, 0, 1, 32'h101, 0, 2, 1, 1, 1, 32'h100, 1, 0);
    for (int i = 0; i < 20; i++)
      add(0, 0, 1, 32'h102 + i, 1, 2, 1, 1, 1, 32'h101 + i, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h115, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 0, 0,       0, 0);
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
